// File: rtl/fu_matrix_ldst_if.sv
// Issue/scratchpad-facing bundle of the matrix load/store unit.
// The slave modport is the functional unit; the master modport is its environment.
interface fu_matrix_ldst_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IMM_W  = 11,
    parameter int unsigned MREG_W = 4
);
    logic              en;
    logic              ls_in;
    logic [MREG_W-1:0] md_in;
    logic [ADDR_W-1:0] rdat1;
    logic [ADDR_W-1:0] rdat2;
    logic [ADDR_W-1:0] imm_in;
    logic              sp_ready;
    logic              sp_done;
    logic [1:0]        ls_out;
    logic [MREG_W-1:0] rd_out;
    logic [IMM_W-1:0]  imm_out;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] stride_out;
    logic              done;
    logic              busy;
    logic              wdog_to;

    modport slave (
        input  en, ls_in, md_in, rdat1, rdat2, imm_in, sp_ready, sp_done,
        output ls_out, rd_out, imm_out, address, stride_out, done, busy, wdog_to
    );

    modport master (
        output en, ls_in, md_in, rdat1, rdat2, imm_in, sp_ready, sp_done,
        input  ls_out, rd_out, imm_out, address, stride_out, done, busy, wdog_to
    );
endinterface

// File: rtl/fu_matrix_ldst.sv
// Matrix load/store functional unit: latches one op, drives a scratchpad request
// through a ready/done handshake and returns a one-cycle done pulse.
module fu_matrix_ldst #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       IMM_W      = 11,
    parameter int unsigned       MREG_W     = 4,
    parameter int unsigned       WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'd1024
) (
    input  logic              CLK,
    input  logic              nRST,
    fu_matrix_ldst_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ls_q, ls_d;
    logic [MREG_W-1:0]   rd_q, rd_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                wdog_to_q, wdog_to_d;
    logic [1:0]          ls_out_q, ls_out_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                accept_s;
    logic [ADDR_W-1:0]   imm_sext_s;
    logic                unused_imm_s;

    assign imm_sext_s   = {{(ADDR_W-IMM_W){bus.imm_in[IMM_W-1]}}, bus.imm_in[IMM_W-1:0]};
    assign unused_imm_s = ^bus.imm_in[ADDR_W-1:IMM_W];

    // Next-state, field latching, watchdog and registered-output decode
    always_comb begin
        state_d   = state_q;
        ls_d      = ls_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        wdog_d    = wdog_q;
        wdog_to_d = wdog_to_q;
        accept_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    accept_s = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.sp_ready && bus.sp_done) begin
                    state_d = ST_DONE;
                end else if (bus.sp_ready) begin
                    state_d = ST_WAIT;
                    wdog_d  = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.sp_done) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    // Saturate so a hung scratchpad cannot wrap the count back under the limit
                    if (wdog_q != {WDOG_W{1'b1}}) begin
                        wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
                    end else begin
                        wdog_d = wdog_q;
                    end
                    if (wdog_d >= WDOG_LIMIT) begin
                        wdog_to_d = 1'b1;
                    end else begin
                        wdog_to_d = wdog_to_q;
                    end
                end
            end
            ST_DONE: begin
                if (bus.en) begin
                    accept_s = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            ls_d     = bus.ls_in;
            rd_d     = bus.md_in;
            imm_d    = bus.imm_in[IMM_W-1:0];
            addr_d   = bus.rdat1 + imm_sext_s;
            stride_d = bus.rdat2;
        end else begin
            ls_d     = ls_q;
        end

        if (state_d == ST_REQ) begin
            ls_out_d = ls_d ? 2'b10 : 2'b01;
        end else begin
            ls_out_d = 2'b00;
        end
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            ls_q      <= 1'b0;
            rd_q      <= '0;
            imm_q     <= '0;
            addr_q    <= '0;
            stride_q  <= '0;
            wdog_q    <= '0;
            wdog_to_q <= 1'b0;
            ls_out_q  <= 2'b00;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ls_q      <= ls_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            wdog_q    <= wdog_d;
            wdog_to_q <= wdog_to_d;
            ls_out_q  <= ls_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ls_out     = ls_out_q;
    assign bus.rd_out     = rd_q;
    assign bus.imm_out    = imm_q;
    assign bus.address    = addr_q;
    assign bus.stride_out = stride_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.wdog_to    = wdog_to_q;

endmodule

// File: tb/tb_fu_matrix_ldst.sv
// Directed bench for fu_matrix_ldst with a shortened watchdog limit of 8.
module tb_fu_matrix_ldst;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    fu_matrix_ldst_if #(.ADDR_W(32), .IMM_W(11), .MREG_W(4)) bus ();

    fu_matrix_ldst #(
        .ADDR_W(32), .IMM_W(11), .MREG_W(4), .WDOG_W(16), .WDOG_LIMIT(16'd8)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic ls, input logic [3:0] md, input logic [31:0] base,
                         input logic [31:0] stride, input logic [31:0] imm);
        bus.en    = 1'b1;
        bus.ls_in = ls;
        bus.md_in = md;
        bus.rdat1 = base;
        bus.rdat2 = stride;
        bus.imm_in = imm;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b0;
        bus.en = 1'b0; bus.ls_in = 1'b0; bus.md_in = 4'd0;
        bus.rdat1 = 32'd0; bus.rdat2 = 32'd0; bus.imm_in = 32'd0;
        bus.sp_ready = 1'b0; bus.sp_done = 1'b0;
        tick();
        tick();
        chk("rst_ls_out",  64'(bus.ls_out),  64'h0);
        chk("rst_busy",    64'(bus.busy),    64'h0);
        chk("rst_done",    64'(bus.done),    64'h0);
        chk("rst_address", 64'(bus.address), 64'h0);
        chk("rst_wdog_to", 64'(bus.wdog_to), 64'h0);
        nRST = 1'b1;

        // Zero-wait load with negative immediate
        issue(1'b1, 4'd5, 32'h0000_1000, 32'h0000_0040, 32'h0000_07FF);
        bus.sp_ready = 1'b1; bus.sp_done = 1'b1;
        tick();
        bus.en = 1'b0;
        chk("ld_ls_out",  64'(bus.ls_out),     64'h2);
        chk("ld_busy",    64'(bus.busy),       64'h1);
        chk("ld_done0",   64'(bus.done),       64'h0);
        chk("ld_address", 64'(bus.address),    64'h0FFF);
        chk("ld_rd_out",  64'(bus.rd_out),     64'h5);
        chk("ld_imm_out", 64'(bus.imm_out),    64'h7FF);
        chk("ld_stride",  64'(bus.stride_out), 64'h40);
        tick();
        chk("ld_done1",   64'(bus.done),       64'h1);
        chk("ld_ls_done", 64'(bus.ls_out),     64'h0);
        chk("ld_busy_dn", 64'(bus.busy),       64'h0);
        bus.sp_ready = 1'b0; bus.sp_done = 1'b0;
        tick();
        chk("ld_done_off", 64'(bus.done),    64'h0);
        chk("ld_hold_adr", 64'(bus.address), 64'h0FFF);

        // Store stalled by sp_ready, then a WAIT phase with an illegal en
        issue(1'b0, 4'd2, 32'h0000_2000, 32'h0000_0008, 32'h0000_0010);
        tick();
        bus.en = 1'b0;
        chk("st_ls_out0", 64'(bus.ls_out),  64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_ls_hold", 64'(bus.ls_out),  64'h1);
            chk("st_adr_hold", 64'(bus.address), 64'h2010);
        end
        bus.sp_ready = 1'b1;
        tick();
        bus.sp_ready = 1'b0;
        chk("st_wait_ls", 64'(bus.ls_out), 64'h0);
        chk("st_wait_bsy", 64'(bus.busy),  64'h1);
        issue(1'b1, 4'd9, 32'h0000_5000, 32'h0000_0001, 32'h0000_0001);
        tick();
        bus.en = 1'b0;
        chk("st_en_ign_rd",  64'(bus.rd_out),  64'h2);
        chk("st_en_ign_adr", 64'(bus.address), 64'h2010);
        chk("st_en_ign_ls",  64'(bus.ls_out),  64'h0);
        bus.sp_done = 1'b1;
        tick();
        bus.sp_done = 1'b0;
        chk("st_done1", 64'(bus.done), 64'h1);
        tick();
        chk("st_done0", 64'(bus.done), 64'h0);

        // Back-to-back issue from DONE
        issue(1'b1, 4'd7, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000);
        bus.sp_ready = 1'b1; bus.sp_done = 1'b1;
        tick();
        bus.en = 1'b0;
        tick();
        chk("b2b_done", 64'(bus.done), 64'h1);
        issue(1'b1, 4'd3, 32'h0000_4000, 32'h0000_0000, 32'h0000_0004);
        bus.sp_ready = 1'b0; bus.sp_done = 1'b0;
        tick();
        bus.en = 1'b0;
        chk("b2b_ls_out", 64'(bus.ls_out),  64'h2);
        chk("b2b_rd_out", 64'(bus.rd_out),  64'h3);
        chk("b2b_adr",    64'(bus.address), 64'h4004);
        chk("b2b_busy",   64'(bus.busy),    64'h1);

        // Reset during WAIT drops the op; a late sp_done is ignored
        bus.sp_ready = 1'b1;
        tick();
        bus.sp_ready = 1'b0;
        chk("rw_in_wait", 64'(bus.busy), 64'h1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        chk("rw_busy",   64'(bus.busy),    64'h0);
        chk("rw_rd_out", 64'(bus.rd_out),  64'h0);
        chk("rw_adr",    64'(bus.address), 64'h0);
        bus.sp_done = 1'b1;
        tick();
        bus.sp_done = 1'b0;
        chk("rw_late_done", 64'(bus.done), 64'h0);
        chk("rw_late_busy", 64'(bus.busy), 64'h0);

        // Watchdog with address wraparound
        issue(1'b1, 4'd4, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0020);
        tick();
        bus.en = 1'b0;
        chk("wd_adr_wrap", 64'(bus.address), 64'h10);
        bus.sp_ready = 1'b1;
        tick();
        bus.sp_ready = 1'b0;
        chk("wd_entry", 64'(bus.wdog_to), 64'h0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("wd_count", 64'(bus.wdog_to), (i >= 8) ? 64'h1 : 64'h0);
        end
        chk("wd_still_busy", 64'(bus.busy), 64'h1);
        bus.sp_done = 1'b1;
        tick();
        bus.sp_done = 1'b0;
        chk("wd_done",  64'(bus.done),    64'h1);
        chk("wd_stick", 64'(bus.wdog_to), 64'h1);
        tick();
        chk("wd_stick2", 64'(bus.wdog_to), 64'h1);
        chk("wd_idle",   64'(bus.done),    64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
